// File: rtl/mem_lsu_if.sv
// Core-side request, BRAM port-B, and writeback/error signals of the load/store unit.
interface mem_lsu_if #(
   parameter int TAG_W = 5
);
   logic             req_valid;
   logic             req_ready;
   logic             req_store;
   logic [2:0]       req_funct3;
   logic [31:0]      req_addr;
   logic [31:0]      req_wdata;
   logic [TAG_W-1:0] req_tag;
   logic             mem_en;
   logic [3:0]       mem_we;
   logic [31:0]      mem_addr;
   logic [31:0]      mem_din;
   logic [31:0]      mem_dout;
   logic             mem_rvalid;
   logic             mem_acc_rd;
   logic             mem_acc_wr;
   logic             ld_valid;
   logic [31:0]      ld_data;
   logic [TAG_W-1:0] ld_tag;
   logic             err_valid;
   logic [1:0]       err_cause;
   logic [31:0]      err_addr;
   logic             spurious_err;

   // LSU side
   modport slave (
      input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_tag,
             mem_dout, mem_rvalid, mem_acc_rd, mem_acc_wr,
      output req_ready, mem_en, mem_we, mem_addr, mem_din,
             ld_valid, ld_data, ld_tag, err_valid, err_cause, err_addr, spurious_err
   );

   // core / memory side
   modport master (
      output req_valid, req_store, req_funct3, req_addr, req_wdata, req_tag,
             mem_dout, mem_rvalid, mem_acc_rd, mem_acc_wr,
      input  req_ready, mem_en, mem_we, mem_addr, mem_din,
             ld_valid, ld_data, ld_tag, err_valid, err_cause, err_addr, spurious_err
   );
endinterface

// File: rtl/mem_lsu.sv
// Load/store unit: turns core requests into word-aligned BRAM accesses with byte
// enables, keeps a FIFO of in-flight loads, and aligns/extends returned data.
module mem_lsu #(
   parameter int QDEPTH = 4,
   parameter int TAG_W  = 5
) (
   input  logic      clk,
   input  logic      rst,
   mem_lsu_if.slave  bus
);
   localparam int PTR_W = $clog2(QDEPTH);

   typedef struct packed {
      logic [2:0]       f3;
      logic [1:0]       off;
      logic [TAG_W-1:0] tag;
   } qent_t;

   qent_t            q_mem_q [QDEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [PTR_W:0]   cnt_q, cnt_d;
   logic             q_full, q_empty;

   logic             illegal, misal, fault;
   logic             accept, good, push, pop;
   logic [1:0]       off;
   logic [3:0]       we_raw;
   logic [31:0]      din_raw;
   qent_t            head_ent;
   logic [31:0]      shifted, ext_data;

   logic             ld_valid_q;
   logic [31:0]      ld_data_q;
   logic [TAG_W-1:0] ld_tag_q;
   logic             err_valid_q;
   logic [1:0]       err_cause_q;
   logic [31:0]      err_addr_q;
   logic             spurious_q;

   assign off     = bus.req_addr[1:0];
   assign q_full  = (cnt_q == (PTR_W+1)'(QDEPTH));
   assign q_empty = (cnt_q == '0);

   // Classify the request: unknown sizes and unsigned stores are illegal, which
   // takes priority over any alignment problem.
   always_comb begin
      illegal = 1'b0;
      misal   = 1'b0;
      case (bus.req_funct3)
         3'b000:         misal = 1'b0;
         3'b001:         misal = bus.req_addr[0];
         3'b010:         misal = |bus.req_addr[1:0];
         3'b100, 3'b101: begin
            illegal = bus.req_store;
            misal   = bus.req_funct3[0] & bus.req_addr[0];
         end
         default:        illegal = 1'b1;
      endcase
   end

   assign fault = illegal | misal;

   // Faulting requests are always consumed; full-queue backpressure uses the
   // registered count only, so a same-cycle pop never frees a slot for a push.
   assign bus.req_ready = ~rst & (fault | (bus.req_store ? bus.mem_acc_wr
                                                         : (bus.mem_acc_rd & ~q_full)));
   assign accept = bus.req_valid & bus.req_ready;
   assign good   = accept & ~fault;
   assign push   = good & ~bus.req_store;
   assign pop    = bus.mem_rvalid & ~q_empty;

   // Store lane steering: byte/half data replicated so any lane sees it.
   always_comb begin
      we_raw  = 4'h0;
      din_raw = 32'h0;
      if (bus.req_store) begin
         case (bus.req_funct3[1:0])
            2'b00: begin
               we_raw  = 4'b0001 << off;
               din_raw = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
               we_raw  = 4'b0011 << off;
               din_raw = {2{bus.req_wdata[15:0]}};
            end
            default: begin
               we_raw  = 4'hF;
               din_raw = bus.req_wdata;
            end
         endcase
      end
   end

   assign bus.mem_en   = good;
   assign bus.mem_we   = good ? we_raw : 4'h0;
   assign bus.mem_din  = din_raw;
   assign bus.mem_addr = {2'b00, bus.req_addr[31:2]};

   // Queue pointer / occupancy next state; power-of-2 depth lets pointers wrap.
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Queue entry storage; contents are don't-care until pushed.
   always_ff @(posedge clk) begin
      if (push) q_mem_q[tail_q] <= '{f3: bus.req_funct3, off: off, tag: bus.req_tag};
   end

   // Align the returned word to the head entry's byte offset and extend.
   always_comb begin
      head_ent = q_mem_q[head_q];
      shifted  = bus.mem_dout >> {head_ent.off, 3'b000};
      case (head_ent.f3)
         3'b000:  ext_data = {{24{shifted[7]}}, shifted[7:0]};
         3'b100:  ext_data = {24'h0, shifted[7:0]};
         3'b001:  ext_data = {{16{shifted[15]}}, shifted[15:0]};
         3'b101:  ext_data = {16'h0, shifted[15:0]};
         default: ext_data = bus.mem_dout;
      endcase
   end

   // Pointers, registered result/error outputs and the sticky spurious flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q      <= '0;
         tail_q      <= '0;
         cnt_q       <= '0;
         ld_valid_q  <= 1'b0;
         ld_data_q   <= '0;
         ld_tag_q    <= '0;
         err_valid_q <= 1'b0;
         err_cause_q <= '0;
         err_addr_q  <= '0;
         spurious_q  <= 1'b0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         cnt_q       <= cnt_d;
         ld_valid_q  <= pop;
         err_valid_q <= accept & fault;
         if (pop) begin
            ld_data_q <= ext_data;
            ld_tag_q  <= head_ent.tag;
         end
         if (accept & fault) begin
            err_cause_q <= illegal ? 2'b10 : 2'b01;
            err_addr_q  <= bus.req_addr;
         end
         if (bus.mem_rvalid & q_empty) spurious_q <= 1'b1;
      end
   end

   assign bus.ld_valid     = ld_valid_q;
   assign bus.ld_data      = ld_data_q;
   assign bus.ld_tag       = ld_tag_q;
   assign bus.err_valid    = err_valid_q;
   assign bus.err_cause    = err_cause_q;
   assign bus.err_addr     = err_addr_q;
   assign bus.spurious_err = spurious_q;
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: table of single-cycle request vectors plus
// hand-written load-return, queue-full and reset sequences.
module tb_mem_lsu;
   localparam int TAG_W = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_lsu_if #(.TAG_W(TAG_W)) bus ();
   mem_lsu #(.QDEPTH(4), .TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic        st;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        acc_rd;
      logic        acc_wr;
      logic        rdy;
      logic        en;
      logic [3:0]  we;
      logic [31:0] maddr;
      logic [31:0] din;
      logic        errv;
      logic [1:0]  cause;
   } vec_t;

   vec_t tv[14];

   function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic acc_rd, input logic acc_wr,
                               input logic rdy, input logic en, input logic [3:0] we,
                               input logic [31:0] din, input logic errv, input logic [1:0] cause);
      vec_t v;
      v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.acc_rd = acc_rd; v.acc_wr = acc_wr;
      v.rdy = rdy; v.en = en; v.we = we; v.maddr = addr >> 2; v.din = din;
      v.errv = errv; v.cause = cause;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle();
      bus.req_valid  = 1'b0;
      bus.req_store  = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      bus.req_tag    = '0;
      bus.mem_dout   = 32'h0;
      bus.mem_rvalid = 1'b0;
      bus.mem_acc_rd = 1'b1;
      bus.mem_acc_wr = 1'b1;
   endtask

   task automatic set_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] tag);
      bus.req_valid  = 1'b1;
      bus.req_store  = 1'b0;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_tag    = tag;
      bus.mem_acc_rd = 1'b1;
   endtask

   // One load request for one cycle; checks handshake and port-B outputs.
   task automatic issue_load(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [4:0] tag, input logic exp_rdy);
      @(negedge clk);
      set_load(f3, addr, tag);
      #1;
      chk({nm, " rdy"}, 32'(bus.req_ready), 32'(exp_rdy));
      chk({nm, " en"}, 32'(bus.mem_en), 32'(exp_rdy));
      if (exp_rdy) begin
         chk({nm, " we"}, 32'(bus.mem_we), 32'h0);
         chk({nm, " maddr"}, bus.mem_addr, addr >> 2);
      end
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
   endtask

   // One memory return cycle; checks the registered result the next cycle.
   task automatic ret(input string nm, input logic [31:0] dout, input logic exp_v,
                      input logic [31:0] exp_d, input logic [4:0] exp_tag);
      @(negedge clk);
      bus.mem_rvalid = 1'b1;
      bus.mem_dout   = dout;
      @(posedge clk);
      #1;
      bus.mem_rvalid = 1'b0;
      chk({nm, " ld_valid"}, 32'(bus.ld_valid), 32'(exp_v));
      if (exp_v) begin
         chk({nm, " ld_data"}, bus.ld_data, exp_d);
         chk({nm, " ld_tag"}, 32'(bus.ld_tag), 32'(exp_tag));
      end
   endtask

   initial begin
      //            st  f3      addr           wdata          rd wr rdy en we     din           ev cause
      tv[0]  = mk(1, 3'b010, 32'h10,        32'hDEADBEEF, 1, 1, 1, 1, 4'hF,  32'hDEADBEEF, 0, 2'b00);
      tv[1]  = mk(1, 3'b000, 32'h13,        32'h123456A5, 1, 1, 1, 1, 4'b1000, 32'hA5A5A5A5, 0, 2'b00);
      tv[2]  = mk(1, 3'b001, 32'h22,        32'hFFFF1234, 1, 1, 1, 1, 4'b1100, 32'h12341234, 0, 2'b00);
      tv[3]  = mk(1, 3'b000, 32'h11,        32'h0000005A, 1, 0, 0, 0, 4'h0,  32'h5A5A5A5A, 0, 2'b00);
      tv[4]  = mk(0, 3'b010, 32'h21,        32'h0,        0, 0, 1, 0, 4'h0,  32'h0,        1, 2'b01);
      tv[5]  = mk(1, 3'b000, 32'h00,        32'h00000077, 1, 1, 1, 1, 4'b0001, 32'h77777777, 0, 2'b00);
      tv[6]  = mk(0, 3'b001, 32'h23,        32'h0,        0, 0, 1, 0, 4'h0,  32'h0,        1, 2'b01);
      tv[7]  = mk(1, 3'b010, 32'h02,        32'h11111111, 0, 0, 1, 0, 4'h0,  32'h0,        1, 2'b01);
      tv[8]  = mk(0, 3'b011, 32'h04,        32'h0,        0, 0, 1, 0, 4'h0,  32'h0,        1, 2'b10);
      tv[9]  = mk(1, 3'b101, 32'h01,        32'h0,        0, 0, 1, 0, 4'h0,  32'h0,        1, 2'b10);
      tv[10] = mk(0, 3'b110, 32'h03,        32'h0,        0, 0, 1, 0, 4'h0,  32'h0,        1, 2'b10);
      tv[11] = mk(1, 3'b001, 32'h21,        32'h0,        0, 0, 1, 0, 4'h0,  32'h0,        1, 2'b01);
      tv[12] = mk(0, 3'b000, 32'h13,        32'h0,        0, 1, 0, 0, 4'h0,  32'h0,        0, 2'b00);
      tv[13] = mk(1, 3'b010, 32'hFFFFFFFC,  32'h0,        1, 1, 1, 1, 4'hF,  32'h0,        0, 2'b00);

      idle();
      repeat (2) @(posedge clk);

      // Reset state: nothing accepted, all registered outputs clear.
      @(negedge clk);
      set_load(3'b010, 32'h0, 5'd1);
      #1;
      chk("rst req_ready", 32'(bus.req_ready), 32'h0);
      chk("rst mem_en", 32'(bus.mem_en), 32'h0);
      chk("rst ld_valid", 32'(bus.ld_valid), 32'h0);
      chk("rst ld_data", bus.ld_data, 32'h0);
      chk("rst ld_tag", 32'(bus.ld_tag), 32'h0);
      chk("rst err_valid", 32'(bus.err_valid), 32'h0);
      chk("rst err_cause", 32'(bus.err_cause), 32'h0);
      chk("rst err_addr", bus.err_addr, 32'h0);
      chk("rst spurious", 32'(bus.spurious_err), 32'h0);
      @(negedge clk);
      idle();
      rst = 1'b0;

      // Single-cycle request vectors.
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         bus.req_valid  = 1'b1;
         bus.req_store  = tv[i].st;
         bus.req_funct3 = tv[i].f3;
         bus.req_addr   = tv[i].addr;
         bus.req_wdata  = tv[i].wdata;
         bus.mem_acc_rd = tv[i].acc_rd;
         bus.mem_acc_wr = tv[i].acc_wr;
         #1;
         chk($sformatf("v%0d rdy", i), 32'(bus.req_ready), 32'(tv[i].rdy));
         chk($sformatf("v%0d en", i), 32'(bus.mem_en), 32'(tv[i].en));
         chk($sformatf("v%0d we", i), 32'(bus.mem_we), 32'(tv[i].we));
         if (tv[i].en) begin
            chk($sformatf("v%0d maddr", i), bus.mem_addr, tv[i].maddr);
            chk($sformatf("v%0d din", i), bus.mem_din, tv[i].din);
         end
         @(posedge clk);
         #1;
         chk($sformatf("v%0d err_valid", i), 32'(bus.err_valid), 32'(tv[i].errv));
         if (tv[i].errv) begin
            chk($sformatf("v%0d err_cause", i), 32'(bus.err_cause), 32'(tv[i].cause));
            chk($sformatf("v%0d err_addr", i), bus.err_addr, tv[i].addr);
         end
         chk($sformatf("v%0d ld_valid", i), 32'(bus.ld_valid), 32'h0);
      end
      @(negedge clk);
      idle();

      // Alignment and extension of returned data.
      issue_load("lb13", 3'b000, 32'h13, 5'd7, 1'b1);
      ret("lb13", 32'hA5000000, 1'b1, 32'hFFFFFFA5, 5'd7);
      @(posedge clk);
      #1;
      chk("ld_valid pulse", 32'(bus.ld_valid), 32'h0);
      issue_load("lbu13", 3'b100, 32'h13, 5'd8, 1'b1);
      ret("lbu13", 32'hA5000000, 1'b1, 32'h000000A5, 5'd8);
      issue_load("lh22", 3'b001, 32'h22, 5'd9, 1'b1);
      ret("lh22", 32'h80010000, 1'b1, 32'hFFFF8001, 5'd9);
      issue_load("lhu22", 3'b101, 32'h22, 5'd10, 1'b1);
      ret("lhu22", 32'h80010000, 1'b1, 32'h00008001, 5'd10);
      issue_load("lb00", 3'b000, 32'h00, 5'd11, 1'b1);
      ret("lb00", 32'h0000007F, 1'b1, 32'h0000007F, 5'd11);
      issue_load("lb01", 3'b000, 32'h01, 5'd12, 1'b1);
      ret("lb01", 32'h00008000, 1'b1, 32'hFFFFFF80, 5'd12);
      issue_load("lw20", 3'b010, 32'h20, 5'd13, 1'b1);
      ret("lw20", 32'h12345678, 1'b1, 32'h12345678, 5'd13);

      // Fill the queue, then exercise pop/push interplay at the full boundary.
      for (int i = 1; i <= 4; i++)
         issue_load($sformatf("fill%0d", i), 3'b010, 32'h40 + 32'(4 * i), 5'(i), 1'b1);
      @(negedge clk);
      set_load(3'b010, 32'h80, 5'd5);
      bus.mem_rvalid = 1'b1;
      bus.mem_dout   = 32'hA1;
      #1;
      chk("full+pop rdy", 32'(bus.req_ready), 32'h0);
      @(posedge clk);
      #1;
      chk("pop1 ld_valid", 32'(bus.ld_valid), 32'h1);
      chk("pop1 ld_data", bus.ld_data, 32'hA1);
      chk("pop1 ld_tag", 32'(bus.ld_tag), 32'd1);
      @(negedge clk);
      bus.mem_dout = 32'hA2;
      #1;
      chk("pop+push rdy", 32'(bus.req_ready), 32'h1);
      chk("pop+push en", 32'(bus.mem_en), 32'h1);
      @(posedge clk);
      #1;
      chk("pop2 ld_data", bus.ld_data, 32'hA2);
      chk("pop2 ld_tag", 32'(bus.ld_tag), 32'd2);
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      set_load(3'b010, 32'h84, 5'd6);
      #1;
      chk("refill rdy", 32'(bus.req_ready), 32'h1);
      @(posedge clk);
      #1;
      chk("refill ld_valid", 32'(bus.ld_valid), 32'h0);
      @(negedge clk);
      set_load(3'b010, 32'h88, 5'd7);
      #1;
      chk("full again rdy", 32'(bus.req_ready), 32'h0);
      @(negedge clk);
      idle();
      ret("drain3", 32'hA3, 1'b1, 32'hA3, 5'd3);
      ret("drain4", 32'hA4, 1'b1, 32'hA4, 5'd4);
      ret("drain5", 32'hA5, 1'b1, 32'hA5, 5'd5);
      ret("drain6", 32'hA6, 1'b1, 32'hA6, 5'd6);
      chk("no spurious yet", 32'(bus.spurious_err), 32'h0);

      // Reset drops in-flight loads; their late returns are spurious.
      issue_load("pre-rst a", 3'b010, 32'h0, 5'd1, 1'b1);
      issue_load("pre-rst b", 3'b010, 32'h4, 5'd2, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid-rst ld_valid", 32'(bus.ld_valid), 32'h0);
      chk("mid-rst spurious", 32'(bus.spurious_err), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      ret("late1", 32'hBEEF, 1'b0, 32'h0, 5'd0);
      chk("late1 spurious", 32'(bus.spurious_err), 32'h1);
      ret("late2", 32'hBEEF, 1'b0, 32'h0, 5'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("spurious sticky", 32'(bus.spurious_err), 32'h1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("spurious cleared", 32'(bus.spurious_err), 32'h0);
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
